// File: rtl/fsm_cmd_filter_pkg.sv
// fsm_cmd_filter_pkg: shared widths and state encoding for the command filter and its downstream consumer.
package fsm_cmd_filter_pkg;
   localparam int CODE_W = 3;
   localparam int ERR_W = 8;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {IDLE, HOLD, CHECK, ISSUE} state_e;
endpackage

// File: rtl/fsm_cmd_filter_cmd_stability_counter.sv
// cmd_stability_counter: holds the candidate code and counts how many consecutive cycles it has been requested.
module cmd_stability_counter
   import fsm_cmd_filter_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inc,
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] cand,
   output logic              match,
   output logic              done
);
   logic [CODE_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      cand_d = load ? code : cand_q;
      cnt_d = load ? CNT_W'(1) : inc ? cnt_q + CNT_W'(1) : cnt_q;
      match = code == cand_q;
      // done looks ahead: this matching cycle is the one that reaches the target
      done = match && (cnt_q + CNT_W'(1) == CNT_W'(STABLE_CYCLES));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= '0;
         cnt_q <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q <= cnt_d;
      end
   end
   assign cand = cand_q;
endmodule

// File: rtl/fsm_cmd_filter.sv
// fsm_cmd_filter: debounces raw request codes, checks them against the downstream sequence rules,
// and either hands a sanitized command downstream or counts a rejection.
module fsm_cmd_filter
   import fsm_cmd_filter_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int NUM_LEGAL = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [CODE_W-1:0] req_code,
   output logic              req_ready,
   output logic              cmd_valid,
   output logic [CODE_W-1:0] cmd_code,
   input  logic              cmd_ready,
   output logic [CODE_W-1:0] cur_code,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_cnt
);
   state_e state_q, state_d;
   logic load, inc, match, done, legal;
   logic [CODE_W-1:0] cand;
   logic cmd_valid_q, cmd_valid_d, err_pulse_q, err_pulse_d;
   logic [CODE_W-1:0] cmd_code_q, cmd_code_d, cur_code_q, cur_code_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   cmd_stability_counter #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
      .clk(clk), .rst(rst), .load(load), .inc(inc), .code(req_code),
      .cand(cand), .match(match), .done(done)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = !req_valid ? IDLE : (STABLE_CYCLES == 1) ? CHECK : HOLD;
         HOLD:  state_d = !req_valid ? IDLE : done ? CHECK : HOLD;
         CHECK: state_d = legal ? ISSUE : IDLE;
         ISSUE: state_d = cmd_ready ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE) && !rst;
      load = req_valid && ((state_q == IDLE) || ((state_q == HOLD) && !match));
      inc = req_valid && (state_q == HOLD) && match;
      // a wrap back to 0 is always allowed, so cur_code+1 never needs to wrap itself
      legal = ({1'b0, cand} < (CODE_W+1)'(NUM_LEGAL)) &&
              (cand == '0 || cand == cur_code_q || {1'b0, cand} == {1'b0, cur_code_q} + (CODE_W+1)'(1));
      cmd_valid_d = ((state_q == CHECK) && legal) || (cmd_valid_q && !((state_q == ISSUE) && cmd_ready));
      cmd_code_d = ((state_q == CHECK) && legal) ? cand : cmd_code_q;
      cur_code_d = ((state_q == ISSUE) && cmd_ready) ? cmd_code_q : cur_code_q;
      err_pulse_d = (state_q == CHECK) && !legal;
      err_cnt_d = (err_pulse_d && err_cnt_q != '1) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_valid_q <= 1'b0;
         cmd_code_q <= '0;
         cur_code_q <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q <= cmd_code_d;
         cur_code_q <= cur_code_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code = cmd_code_q;
   assign cur_code = cur_code_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_fsm_cmd_filter.sv
// tb_fsm_cmd_filter: randomized request episodes scored against a transaction-level model of the filter.
module tb_fsm_cmd_filter;
   localparam int N = 4;
   localparam int L = 5;

   typedef struct {
      bit err;
      int val;
   } ev_t;

   logic clk, rst, req_valid, req_ready, cmd_valid, cmd_ready, err_pulse;
   logic [2:0] req_code, cmd_code, cur_code;
   logic [7:0] err_cnt;

   int n_checks, n_fail, mcur, merr, exp_cmd;
   bit mon_en, rnd_rdy;
   ev_t exp_q[$];

   fsm_cmd_filter #(.STABLE_CYCLES(N), .NUM_LEGAL(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
      .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready), .cur_code(cur_code),
      .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: the first run held for N cycles is evaluated; everything after it in the episode is never driven.
   task automatic episode(input int codes[$], input int lens[$]);
      int ev, cut, w;
      ev_t e;
      ev = -1;
      cut = codes.size();
      foreach (codes[i]) if (ev < 0 && lens[i] >= N) begin ev = codes[i]; cut = i; end
      if (ev >= 0) begin
         if (ev < L && (ev == 0 || ev == mcur || ev == mcur + 1)) begin
            e.err = 0; e.val = ev; mcur = ev;
         end else begin
            merr = (merr < 255) ? merr + 1 : 255;
            e.err = 1; e.val = merr;
         end
         exp_q.push_back(e);
      end
      for (int i = 0; i < codes.size() && i <= cut; i++) begin
         repeat ((i == cut) ? N : lens[i]) begin
            req_valid = 1; req_code = 3'(codes[i]);
            @(posedge clk); #1;
         end
      end
      req_valid = 0;
      w = 0;
      do begin @(posedge clk); #1; w++; end while (!req_ready && w < 300);
      if (!req_ready) chk("idle_timeout", 0, 1);
   endtask

   task automatic ep1(input int code, input int len);
      int c[$], l[$];
      c.push_back(code); l.push_back(len);
      episode(c, l);
   endtask

   initial forever begin
      @(posedge clk); #2;
      if (rnd_rdy) cmd_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      bit prev_valid, hs_pend;
      int hs_code;
      ev_t e;
      prev_valid = 0; hs_pend = 0; hs_code = 0;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            if (hs_pend) begin chk("cur_code", cur_code, hs_code); hs_pend = 0; end
            if (cmd_valid && !prev_valid) begin
               if (exp_q.size() == 0) chk("cmd_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("cmd_kind", e.err, 0);
                  chk("cmd_code", cmd_code, e.val);
                  exp_cmd = e.val;
               end
               chk("err_with_cmd", err_pulse, 0);
            end else if (cmd_valid) begin
               chk("cmd_hold", cmd_code, exp_cmd);
               chk("ready_in_issue", req_ready, 0);
            end
            if (err_pulse) begin
               if (exp_q.size() == 0) chk("err_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("err_kind", e.err, 1);
                  chk("err_cnt", err_cnt, e.val);
               end
            end
            if (cmd_valid && cmd_ready) begin hs_pend = 1; hs_code = exp_cmd; end
         end
         prev_valid = cmd_valid;
      end
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w, lat, code, prev, k;
      int c[$], l[$];
      n_checks = 0; n_fail = 0; mon_en = 0; rnd_rdy = 0; exp_cmd = 0;
      rst = 1; req_valid = 0; req_code = 0; cmd_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_code", cmd_code, 0);
      chk("rst_cur_code", cur_code, 0);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst = 0;
      @(posedge clk); #1;
      chk("post_rst_ready", req_ready, 1);

      req_valid = 1; req_code = 1;
      repeat (N) @(posedge clk);
      #1;
      req_valid = 0;
      w = 0;
      while (!cmd_valid && w < 20) begin @(posedge clk); #1; w++; end
      chk("stall_rise", cmd_valid, 1);
      repeat (10) begin
         @(posedge clk); #1;
         chk("stall_valid", cmd_valid, 1);
         chk("stall_code", cmd_code, 1);
         chk("stall_req_ready", req_ready, 0);
      end
      rst = 1;
      @(posedge clk); #1;
      chk("issue_rst_valid", cmd_valid, 0);
      chk("issue_rst_code", cmd_code, 0);
      chk("issue_rst_cur", cur_code, 0);
      chk("issue_rst_err", err_cnt, 0);
      chk("issue_rst_ready", req_ready, 0);
      rst = 0;
      @(posedge clk); #1;
      chk("issue_rst_after", req_ready, 1);

      cmd_ready = 1; req_valid = 1; req_code = 1; lat = 0;
      for (int cy = 1; cy <= 12; cy++) begin
         @(posedge clk); #1;
         if (cy == N) req_valid = 0;
         if (cmd_valid && lat == 0) begin lat = cy; chk("lat_code", cmd_code, 1); end
      end
      chk("latency", lat, N + 1);
      chk("lat_cur", cur_code, 1);
      chk("lat_idle", req_ready, 1);

      mcur = 1; merr = 0; mon_en = 1; rnd_rdy = 1;
      ep1(3, N);
      c.delete(); l.delete();
      c.push_back(2); l.push_back(2); c.push_back(5); l.push_back(4);
      episode(c, l);
      repeat (300) ep1(6, N);
      chk("err_sat", err_cnt, 255);
      ep1(2, N); ep1(3, N); ep1(4, N); ep1(0, N);
      chk("wrap_cur", cur_code, 0);

      repeat (150) begin
         c.delete(); l.delete();
         prev = -1;
         repeat ($urandom_range(1, 3)) begin
            k = $urandom_range(0, 3);
            code = (k == 0) ? 0 : (k == 1) ? mcur : (k == 2) ? (mcur + 1) % 8 : int'($urandom_range(0, 7));
            if (code == prev) code = (code + 3) % 8;
            c.push_back(code); l.push_back($urandom_range(1, N + 1));
            prev = code;
         end
         episode(c, l);
      end

      repeat (5) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
